// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor. The operand is split into N = WIDTH/SEG
// segments. Each stage ripples one segment and registers its carry for the next stage.
// Low result segments move forward unchanged. High operand segments wait in the skew
// registers until their stage computes them.
module pipelined_rca #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             ovf
);

   localparam int unsigned N = WIDTH / SEG;

   if ((WIDTH % SEG) != 0) begin : g_bad_seg
      $error("pipelined_rca: WIDTH must be a multiple of SEG");
   end

   // Stage registers: valid, skewed operands, partial sum and segment carry.
   logic             r_v  [N];
   logic [WIDTH-1:0] r_a  [N];
   logic [WIDTH-1:0] r_b  [N];
   logic [WIDTH-1:0] r_s  [N];
   logic             r_c  [N];
   logic             r_cm;

   // Per-stage inputs (from the previous stage or from the ports) and per-stage results.
   logic [WIDTH-1:0] w_a_in  [N];
   logic [WIDTH-1:0] w_b_in  [N];
   logic [WIDTH-1:0] w_s_in  [N];
   logic             w_c_in  [N];
   logic [WIDTH-1:0] w_s_out [N];
   logic             w_c_out [N];
   logic [SEG-1:0]   w_seg;
   logic             w_cm;
   logic             w_stall;

   // Stall only when a finished result is blocked downstream. This signal has no path from in_valid.
   assign w_stall  = r_v[N-1] & ~out_ready;
   assign in_ready = ~w_stall;

   // Stage inputs and the ripple add of the segment owned by each stage.
   always_comb begin
      w_seg     = '0;
      w_a_in[0] = A;
      w_b_in[0] = sub ? ~B : B;
      w_s_in[0] = '0;
      w_c_in[0] = sub | C;
      for (int k = 1; k < N; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_s_in[k] = r_s[k-1];
         w_c_in[k] = r_c[k-1];
      end
      for (int k = 0; k < N; k++) begin
         {w_c_out[k], w_seg} = {1'b0, w_a_in[k][k*SEG +: SEG]}
                             + {1'b0, w_b_in[k][k*SEG +: SEG]}
                             + {{SEG{1'b0}}, w_c_in[k]};
         w_s_out[k]                  = w_s_in[k];
         w_s_out[k][k*SEG +: SEG]    = w_seg;
      end
   end

   // The carry into the MSB is recovered from the MSB sum bit, so no separate adder is needed.
   assign w_cm = w_a_in[N-1][WIDTH-1] ^ w_b_in[N-1][WIDTH-1] ^ w_s_out[N-1][WIDTH-1];

   // Pipeline advance. Every stage holds together while stalled, and reset clears all state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            r_v[k] <= 1'b0;
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
         r_cm <= 1'b0;
      end else if (!w_stall) begin
         r_v[0] <= in_valid;
         for (int k = 1; k < N; k++) begin
            r_v[k] <= r_v[k-1];
         end
         for (int k = 0; k < N; k++) begin
            r_a[k] <= w_a_in[k];
            r_b[k] <= w_b_in[k];
            r_s[k] <= w_s_out[k];
            r_c[k] <= w_c_out[k];
         end
         r_cm <= w_cm;
      end
   end

   assign out_valid = r_v[N-1];
   assign S         = r_s[N-1];
   assign Cout      = r_c[N-1];
   assign ovf       = r_c[N-1] ^ r_cm;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed vector table, streaming, random backpressure, reset, N=1.
module tb_pipelined_rca;

   localparam int W  = 16;
   localparam int SG = 4;
   localparam int NS = W / SG;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, C, sub, out_valid, out_ready, Cout, ovf;
   logic [15:0] A, B, S;

   logic        n1_rst, n1_in_valid, n1_in_ready, n1_C, n1_sub, n1_out_valid, n1_out_ready;
   logic        n1_Cout, n1_ovf;
   logic [7:0]  n1_A, n1_B, n1_S;

   pipelined_rca #(.WIDTH(W), .SEG(SG)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .C(C),
      .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout), .ovf(ovf)
   );

   pipelined_rca #(.WIDTH(8), .SEG(8)) u_dut_n1 (
      .clk(clk), .rst(n1_rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .A(n1_A),
      .B(n1_B), .C(n1_C), .sub(n1_sub), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
      .S(n1_S), .Cout(n1_Cout), .ovf(n1_ovf)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic        sub;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
      int          due;
   } exp_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   exp_t        sb[$];
   vec_t        vt[8];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_s;
   logic        prev_cout, prev_ovf;

   // Reference: plain unsigned/signed integer arithmetic, returns {ovf, cout, s}.
   function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
      int lim, half, ua, ub, full, sa, sbv, r;
      logic cout, ov;
      lim  = 1 << w;
      half = 1 << (w - 1);
      ua   = int'(a) & (lim - 1);
      ub   = int'(b) & (lim - 1);
      full = s ? (ua - ub) : (ua + ub + int'(c));
      sa   = (ua >= half) ? ua - lim : ua;
      sbv  = (ub >= half) ? ub - lim : ub;
      r    = s ? (sa - sbv) : (sa + sbv + int'(c));
      cout = s ? (ua >= ub) : (full >= lim);
      ov   = (r >= half) || (r < -half);
      return {ov, cout, 16'(full & (lim - 1))};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One cycle of the main DUT against the scoreboard. strict also checks exact latency.
   task automatic cycle(input logic vld, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic rdy, input logic strict);
      logic [17:0] m;
      exp_t        e;
      in_valid  = vld;
      A         = a;
      B         = b;
      C         = c;
      sub       = s;
      out_ready = rdy;
      #1;
      if (prev_stall) begin
         check("stall_valid", out_valid, 1'b1);
         check("stall_S", S, prev_s);
         check("stall_Cout", Cout, prev_cout);
         check("stall_ovf", ovf, prev_ovf);
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out", 1'b1, 1'b0);
         end else begin
            check("S", S, sb[0].s);
            check("Cout", Cout, sb[0].cout);
            check("ovf", ovf, sb[0].ovf);
            if (strict) check("latency", cyc, sb[0].due);
            if (out_ready) void'(sb.pop_front());
         end
      end else if (strict && sb.size() > 0) begin
         check("missing_out", (sb[0].due == cyc), 1'b0);
      end
      if (vld && in_ready) begin
         m      = ref_op(W, a, b, c, s);
         e.s    = m[15:0];
         e.cout = m[16];
         e.ovf  = m[17];
         e.due  = cyc + NS;
         sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = S;
      prev_cout  = Cout;
      prev_ovf   = ovf;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] m;
      logic [7:0]  ra, rb;
      logic        rc, rs;

      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vt[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

      // Reset held two cycles while offering an operation.
      rst = 1'b1; in_valid = 1'b1; A = 16'h1234; B = 16'h1111; C = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      n1_rst = 1'b1; n1_in_valid = 1'b0; n1_A = '0; n1_B = '0; n1_C = 1'b0; n1_sub = 1'b0;
      n1_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_S", S, 16'h0000);
         check("rst_Cout", Cout, 1'b0);
         check("rst_ovf", ovf, 1'b0);
      end
      rst = 1'b0; n1_rst = 1'b0; in_valid = 1'b0;
      check("n1_rst_out_valid", n1_out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < NS + 2; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Directed vectors with exact latency.
      for (int v = 0; v < 8; v++) begin
         in_valid = 1'b1; A = vt[v].a; B = vt[v].b; C = vt[v].c; sub = vt[v].sub;
         out_ready = 1'b1;
         #1;
         check("vec_in_ready", in_ready, 1'b1);
         tick();
         in_valid = 1'b0;
         for (int i = 1; i <= NS; i++) begin
            if (i < NS) begin
               check("vec_early_valid", out_valid, 1'b0);
               tick();
            end else begin
               check("vec_out_valid", out_valid, 1'b1);
               check("vec_S", S, vt[v].s);
               check("vec_Cout", Cout, vt[v].cout);
               check("vec_ovf", ovf, vt[v].ovf);
            end
         end
         tick();
         check("vec_single_valid", out_valid, 1'b0);
      end

      // Eight back-to-back random ops with no backpressure.
      prev_stall = 1'b0;
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < NS + 3; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("stream_drained", sb.size(), 0);

      // Random input gaps with random backpressure.
      for (int i = 0; i < 300; i++)
         cycle(1'(($urandom % 4) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), 1'(($urandom % 3) != 0), 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("random_drained", sb.size(), 0);

      // Reset with three ops in flight. None of them may emerge afterwards.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
      rst = 1'b1; in_valid = 1'b1; A = 16'hAAAA; B = 16'h5555;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_S", S, 16'h0000);
      sb.delete();
      prev_stall = 1'b0;
      cycle(1'b1, 16'hC0DE, 16'h1F2E, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < NS + 4; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("midrst_drained", sb.size(), 0);

      // N = 1 instance: single registered adder with one-cycle latency.
      n1_in_valid = 1'b1; n1_A = 8'hF0; n1_B = 8'h0F; n1_C = 1'b1; n1_sub = 1'b0;
      #1;
      check("n1_in_ready", n1_in_ready, 1'b1);
      check("n1_pre_valid", n1_out_valid, 1'b0);
      tick();
      n1_in_valid = 1'b0;
      check("n1_out_valid", n1_out_valid, 1'b1);
      check("n1_S", n1_S, 8'h00);
      check("n1_Cout", n1_Cout, 1'b1);
      check("n1_ovf", n1_ovf, 1'b0);
      tick();
      check("n1_single_valid", n1_out_valid, 1'b0);
      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         n1_in_valid = 1'b1; n1_A = ra; n1_B = rb; n1_C = rc; n1_sub = rs;
         tick();
         m = ref_op(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
         check("n1_rand_valid", n1_out_valid, 1'b1);
         check("n1_rand_S", n1_S, m[7:0]);
         check("n1_rand_Cout", n1_Cout, m[16]);
         check("n1_rand_ovf", n1_ovf, m[17]);
      end
      n1_in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
